// File: rtl/thor2022_rfwr_arbiter.sv
// rtl/thor2022_rfwr_arbiter.sv - age-aware round-robin arbiter for the two register-file write ports
module thor2022_rfwr_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 64,
  parameter int IDW  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDW-1:0]       head,
  input  logic                 flush,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*IDW-1:0]  req_id,
  input  logic [NREQ*6-1:0]    req_rt,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      ack,
  output logic                 wr0,
  output logic                 wr1,
  output logic [5:0]           wa0,
  output logic [5:0]           wa1,
  output logic [DW-1:0]        wd0,
  output logic [DW-1:0]        wd1,
  output logic [IDW-1:0]       wid0,
  output logic [IDW-1:0]       wid1,
  output logic                 stall,
  output logic [15:0]          conflict_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDW-1:0] id_a   [NREQ];
  logic [IDW-1:0] age_a  [NREQ];
  logic [5:0]     rt_a   [NREQ];
  logic [DW-1:0]  data_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign id_a[g]   = req_id[g*IDW +: IDW];
    assign rt_a[g]   = req_rt[g*6 +: 6];
    assign data_a[g] = req_data[g*DW +: DW];
    assign age_a[g]  = id_a[g] - head;
  end

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  logic [NREQ-1:0] elig, zero_rt, blocked, cand, gnt;
  logic            g0, g1;
  logic [PW-1:0]   p0, p1, rr_q, rr_d;

  logic            wr0_q, wr1_q;
  logic [5:0]      wa0_q, wa1_q;
  logic [DW-1:0]   wd0_q, wd1_q;
  logic [IDW-1:0]  wid0_q, wid1_q;
  logic [15:0]     cnt_q, cnt_d;

  // An older eligible write to the same register holds back every younger one.
  always_comb begin
    elig    = req & {NREQ{~flush}};
    zero_rt = '0;
    blocked = '0;
    for (int i = 0; i < NREQ; i++) begin
      zero_rt[i] = (rt_a[i] == 6'd0);
      for (int j = 0; j < NREQ; j++) begin
        if (j != i && elig[i] && elig[j] && rt_a[i] != 6'd0 &&
            rt_a[j] == rt_a[i] && age_a[j] < age_a[i])
          blocked[i] = 1'b1;
      end
    end
    cand = elig & ~zero_rt & ~blocked;
  end

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    p0 = '0;
    p1 = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (cand[wrap_add(rr_q, k)]) begin
        if (!g0) begin
          g0 = 1'b1;
          p0 = wrap_add(rr_q, k);
        end else if (!g1 && rt_a[wrap_add(rr_q, k)] != rt_a[p0]) begin
          g1 = 1'b1;
          p1 = wrap_add(rr_q, k);
        end
      end
    end
    gnt = '0;
    if (g0) gnt[p0] = 1'b1;
    if (g1) gnt[p1] = 1'b1;
    if (g1)      rr_d = wrap_add(p1, 1);
    else if (g0) rr_d = wrap_add(p0, 1);
    else         rr_d = rr_q;
    cnt_d = cnt_q;
    if (|blocked && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  assign ack   = gnt | (elig & zero_rt);
  assign stall = |(elig & ~zero_rt & ~ack);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr0_q  <= 1'b0;
      wr1_q  <= 1'b0;
      wa0_q  <= '0;
      wa1_q  <= '0;
      wd0_q  <= '0;
      wd1_q  <= '0;
      wid0_q <= '0;
      wid1_q <= '0;
      rr_q   <= '0;
      cnt_q  <= '0;
    end else begin
      wr0_q <= g0;
      wr1_q <= g1;
      if (g0) begin
        wa0_q  <= rt_a[p0];
        wd0_q  <= data_a[p0];
        wid0_q <= id_a[p0];
      end
      if (g1) begin
        wa1_q  <= rt_a[p1];
        wd1_q  <= data_a[p1];
        wid1_q <= id_a[p1];
      end
      rr_q  <= rr_d;
      cnt_q <= cnt_d;
    end
  end

  assign wr0          = wr0_q;
  assign wr1          = wr1_q;
  assign wa0          = wa0_q;
  assign wa1          = wa1_q;
  assign wd0          = wd0_q;
  assign wd1          = wd1_q;
  assign wid0         = wid0_q;
  assign wid1         = wid1_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_thor2022_rfwr_arbiter.sv
// tb/tb_thor2022_rfwr_arbiter.sv - directed and randomized checks of the write-port arbiter against a queue-based model
module tb_thor2022_rfwr_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [2:0]  head = 3'd0;
  logic [3:0]  req = 4'd0;
  logic [2:0]  r_id   [4];
  logic [5:0]  r_rt   [4];
  logic [63:0] r_data [4];
  logic [11:0]  req_id;
  logic [23:0]  req_rt;
  logic [255:0] req_data;

  logic [3:0]  ack;
  logic        wr0, wr1, stall;
  logic [5:0]  wa0, wa1;
  logic [63:0] wd0, wd1;
  logic [2:0]  wid0, wid1;
  logic [15:0] conflict_cnt;

  for (genvar g = 0; g < 4; g++) begin : g_pack
    assign req_id[g*3 +: 3]    = r_id[g];
    assign req_rt[g*6 +: 6]    = r_rt[g];
    assign req_data[g*64 +: 64] = r_data[g];
  end

  thor2022_rfwr_arbiter #(.NREQ(4), .DW(64), .IDW(3)) dut (
    .clk(clk), .rst(rst), .head(head), .flush(flush), .req(req),
    .req_id(req_id), .req_rt(req_rt), .req_data(req_data), .ack(ack),
    .wr0(wr0), .wr1(wr1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .wid0(wid0), .wid1(wid1), .stall(stall), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic int age_of(input int i);
    return (int'(r_id[i]) - int'(head) + 8) % 8;
  endfunction

  // Oldest eligible writer per register wins; survivors are listed in round-robin order.
  function automatic void model(input int rr, output logic [3:0] a, output logic st,
                                output bit g0, output int p0, output bit g1, output int p1,
                                output bit blk);
    int best[64];
    int q[$];
    logic [3:0] el;
    el = flush ? 4'd0 : req;
    foreach (best[r]) best[r] = -1;
    for (int i = 0; i < 4; i++)
      if (el[i] && r_rt[i] != 0)
        if (best[r_rt[i]] < 0 || age_of(i) < age_of(best[r_rt[i]])) best[r_rt[i]] = i;
    a = 4'd0; blk = 0; g0 = 0; g1 = 0; p0 = 0; p1 = 0; st = 1'b0;
    for (int i = 0; i < 4; i++)
      if (el[i]) begin
        if (r_rt[i] == 0) a[i] = 1'b1;
        else if (best[r_rt[i]] != i) blk = 1;
      end
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (rr + k) % 4;
      if (el[i] && r_rt[i] != 0 && best[r_rt[i]] == i) q.push_back(i);
    end
    if (q.size() > 0) begin
      g0 = 1; p0 = q[0]; a[p0] = 1'b1;
      for (int m = 1; m < q.size(); m++)
        if (r_rt[q[m]] != r_rt[p0]) begin
          g1 = 1; p1 = q[m]; a[p1] = 1'b1;
          break;
        end
    end
    for (int i = 0; i < 4; i++)
      if (el[i] && r_rt[i] != 0 && !a[i]) st = 1'b1;
  endfunction

  int          m_rr;
  logic [15:0] m_cnt;
  bit          e_wr0, e_wr1;
  logic [5:0]  e_wa0, e_wa1;
  logic [63:0] e_wd0, e_wd1;
  logic [2:0]  e_wid0, e_wid1;
  logic [3:0]  m_ack_last = 4'd0;

  always @(negedge clk) begin
    logic [3:0] a;
    logic st;
    bit g0, g1, blk;
    int p0, p1;
    if (rst) begin
      m_rr = 0; m_cnt = 16'd0; e_wr0 = 0; e_wr1 = 0; m_ack_last = 4'd0;
    end else begin
      model(m_rr, a, st, g0, p0, g1, p1, blk);
      chk("ack", ack, a);
      chk("stall", stall, st);
      chk("wr0", wr0, e_wr0);
      chk("wr1", wr1, e_wr1);
      if (e_wr0) begin
        chk("wa0", wa0, e_wa0); chk("wd0", wd0, e_wd0); chk("wid0", wid0, e_wid0);
      end
      if (e_wr1) begin
        chk("wa1", wa1, e_wa1); chk("wd1", wd1, e_wd1); chk("wid1", wid1, e_wid1);
      end
      chk("conflict_cnt", conflict_cnt, m_cnt);
      e_wr0 = g0;
      e_wr1 = g1;
      if (g0) begin e_wa0 = r_rt[p0]; e_wd0 = r_data[p0]; e_wid0 = r_id[p0]; end
      if (g1) begin e_wa1 = r_rt[p1]; e_wd1 = r_data[p1]; e_wid1 = r_id[p1]; end
      if (g1) m_rr = (p1 + 1) % 4;
      else if (g0) m_rr = (p0 + 1) % 4;
      if (blk && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      m_ack_last = a;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'd0; flush = 1'b0; head = 3'd0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [5:0] rt, input logic [2:0] id, input logic [63:0] d);
    r_rt[i] = rt; r_id[i] = id; r_data[i] = d;
  endtask

  initial begin
    logic [3:0] pend;
    logic [7:0] used;
    for (int i = 0; i < 4; i++) set_req(i, 6'd0, 3'd0, 64'd0);
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("rst_wr0", wr0, 1'b0);
    chk("rst_cnt", conflict_cnt, 16'd0);

    // single request, then a pair that reveals rr_ptr moved to 1
    set_req(0, 6'd5, 3'd2, 64'hA5); req = 4'b0001;
    #1 chk("t1_ack", ack, 4'b0001); chk("t1_stall", stall, 1'b0);
    cyc(); req = 4'd0;
    chk("t1_wr0", wr0, 1'b1); chk("t1_wa0", wa0, 6'd5); chk("t1_wd0", wd0, 64'hA5);
    chk("t1_wid0", wid0, 3'd2); chk("t1_wr1", wr1, 1'b0);
    set_req(0, 6'd1, 3'd0, 64'h11); set_req(1, 6'd2, 3'd1, 64'h22); req = 4'b0011;
    #1 chk("rr1_ack", ack, 4'b0011);
    cyc(); req = 4'd0;
    chk("rr1_wa0", wa0, 6'd2); chk("rr1_wa1", wa1, 6'd1);

    // four distinct targets share two ports over two cycles
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 6'(i + 1), 3'(i), 64'(100 + i));
    req = 4'b1111;
    #1 chk("t2_ack1", ack, 4'b0011); chk("t2_stall1", stall, 1'b1);
    cyc(); req = 4'b1100;
    chk("t2_wa0a", wa0, 6'd1); chk("t2_wa1a", wa1, 6'd2);
    #1 chk("t2_ack2", ack, 4'b1100); chk("t2_stall2", stall, 1'b0);
    cyc(); req = 4'd0;
    chk("t2_wa0b", wa0, 6'd3); chk("t2_wa1b", wa1, 6'd4);

    // same target: the older id writes first
    do_reset();
    set_req(0, 6'd7, 3'd3, 64'h30); set_req(1, 6'd7, 3'd1, 64'h10); req = 4'b0011;
    #1 chk("t3_ack1", ack, 4'b0010); chk("t3_stall1", stall, 1'b1);
    cyc(); req = 4'b0001;
    chk("t3_wa0", wa0, 6'd7); chk("t3_wid0a", wid0, 3'd1); chk("t3_wr1", wr1, 1'b0);
    chk("t3_cnt1", conflict_cnt, 16'd1);
    #1 chk("t3_ack2", ack, 4'b0001);
    cyc(); req = 4'd0;
    chk("t3_wid0b", wid0, 3'd3);
    head = 3'd2; req = 4'b0011;
    #1 chk("t3h_ack1", ack, 4'b0001);
    cyc(); req = 4'b0010;
    chk("t3h_wid0a", wid0, 3'd3); chk("t3h_cnt", conflict_cnt, 16'd2);
    #1 chk("t3h_ack2", ack, 4'b0010);
    cyc(); req = 4'd0;
    chk("t3h_wid0b", wid0, 3'd1);

    // Rt==0 requests are acknowledged and dropped
    do_reset();
    set_req(0, 6'd0, 3'd0, 64'h1); set_req(1, 6'd9, 3'd1, 64'h99); set_req(2, 6'd10, 3'd2, 64'hAA);
    req = 4'b0111;
    #1 chk("t4_ack", ack, 4'b0111);
    cyc(); req = 4'd0;
    chk("t4_wr0", wr0, 1'b1); chk("t4_wa0", wa0, 6'd9);
    chk("t4_wr1", wr1, 1'b1); chk("t4_wa1", wa1, 6'd10); chk("t4_wd1", wd1, 64'hAA);

    // flush suppresses acks but lets an already registered write finish
    set_req(0, 6'd5, 3'd0, 64'h55); req = 4'b0001;
    #1 chk("t5_ack0", ack, 4'b0001);
    cyc();
    set_req(1, 6'd6, 3'd1, 64'h66); set_req(2, 6'd7, 3'd2, 64'h77); req = 4'b0110; flush = 1'b1;
    #1 chk("t5_ack_fl", ack, 4'b0000); chk("t5_stall_fl", stall, 1'b0);
    chk("t5_wr0_fl", wr0, 1'b1); chk("t5_wa0_fl", wa0, 6'd5);
    cyc(); flush = 1'b0;
    chk("t5_wr0_after", wr0, 1'b0); chk("t5_wr1_after", wr1, 1'b0);
    #1 chk("t5_ack_resume", ack, 4'b0110);
    cyc(); req = 4'd0;

    // asynchronous reset between edges
    do_reset();
    set_req(0, 6'd7, 3'd3, 64'h30); set_req(1, 6'd7, 3'd1, 64'h10); req = 4'b0011;
    cyc(); req = 4'b0001;
    chk("t6_wr0_pre", wr0, 1'b1); chk("t6_cnt_pre", conflict_cnt, 16'd1);
    #1 rst = 1'b1;
    #1 chk("t6_wr0_rst", wr0, 1'b0); chk("t6_cnt_rst", conflict_cnt, 16'd0);
    req = 4'd0;
    cyc(); rst = 1'b0;
    set_req(0, 6'd1, 3'd0, 64'h11); set_req(1, 6'd2, 3'd1, 64'h22); req = 4'b0011;
    #1 chk("t6_ack", ack, 4'b0011);
    cyc(); req = 4'd0;
    chk("t6_wa0", wa0, 6'd1); chk("t6_wa1", wa1, 6'd2);

    // randomized traffic, requests held until the model acknowledges them
    do_reset();
    pend = 4'd0;
    repeat (3000) begin
      cyc();
      pend = pend & ~m_ack_last;
      used = 8'd0;
      for (int i = 0; i < 4; i++) if (pend[i]) used[r_id[i]] = 1'b1;
      for (int i = 0; i < 4; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          int s;
          s = $urandom_range(0, 7);
          for (int k = 0; k < 8; k++)
            if (!used[(s + k) % 8]) begin
              r_id[i] = 3'((s + k) % 8);
              used[(s + k) % 8] = 1'b1;
              break;
            end
          r_rt[i] = 6'($urandom_range(0, 5));
          r_data[i] = {$urandom, $urandom};
          pend[i] = 1'b1;
        end
      req = pend;
      flush = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 7) == 0) head = 3'($urandom_range(0, 7));
    end

    // saturation of the conflict counter
    do_reset();
    set_req(0, 6'd7, 3'd1, 64'h71); set_req(1, 6'd7, 3'd2, 64'h72); req = 4'b0011;
    repeat (65540) cyc();
    chk("sat_cnt", conflict_cnt, 16'hFFFF);
    req = 4'd0;
    cyc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
